lr_infer_ctrl: RTL and testbench

- Sequencer for the linear-regression datapath. Holds N_FEAT weights and one bias in a config register file.
- Accepts a stream of feature samples over a valid/ready handshake and accumulates y = sum(w[i]*x[i]) + b through one shared multiply-accumulate, one feature per cycle.
- Presents each result on a valid/ready output port.
- Sits between the feature source (sensor/host FIFO) and the result consumer; the config port is driven by the host register interface.

---
 rtl/lr_infer_ctrl.sv | 173 +++++++++++++++++
 tb/tb_lr_infer_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lr_infer_ctrl.sv
// Linear-regression inference sequencer: one shared MAC computes y = sum(w[i]*x[i]) + b.
// Optional clamp-on-overflow output is enabled by defining LRM_SAT_EN.
module lr_infer_ctrl #(
  parameter int N_FEAT = 4,
  parameter int DW     = 4,
  parameter int OW     = 8,
  localparam int AW    = $clog2(N_FEAT + 1),
  localparam int ACCW  = 2 * DW + $clog2(N_FEAT) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we_i,
  input  logic [AW-1:0] cfg_addr_i,
  input  logic [DW-1:0] cfg_wdata_i,
  output logic          cfg_err_o,
  input  logic          cfg_err_clr_i,
  input  logic          x_valid_i,
  output logic          x_ready_o,
  input  logic [DW-1:0] x_data_i,
  output logic          y_valid_o,
  input  logic          y_ready_i,
  output logic [OW-1:0] y_data_o,
  output logic          y_sat_o,
  output logic          busy_o
);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   w_q [N_FEAT];
  logic [DW-1:0]   bias_q;
  logic [ACCW-1:0] acc_q, acc_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic            yvalid_q, yvalid_d;
  logic [OW-1:0]   ydata_q, ydata_d;
  logic            cfg_err_q, cfg_err_d;
  logic            cfg_hit, cfg_drop;

  logic [DW-1:0]   cur_w;
  logic [ACCW-1:0] prod;
  logic [ACCW-1:0] partial;
  logic [OW-1:0]   result;

`ifdef LRM_SAT_EN
  localparam logic [ACCW-1:0] YMAX = {{(ACCW-OW){1'b0}}, {OW{1'b1}}};
  logic            ysat_q, ysat_d;
  logic [ACCW-1:0] total;
  logic            sat_hit;
`endif

  // Weight for the feature currently being multiplied; idx is 0 in IDLE
  always_comb begin
    cur_w = '0;
    for (int i = 0; i < N_FEAT; i++) begin
      if (idx_q == AW'(i)) cur_w = w_q[i];
    end
  end

  assign prod    = ACCW'(cur_w) * ACCW'(x_data_i);
  assign partial = ((state_q == ACC) ? acc_q : '0) + prod;

`ifdef LRM_SAT_EN
  assign total   = partial + ACCW'(bias_q);
  assign sat_hit = total > YMAX;
  assign result  = sat_hit ? {OW{1'b1}} : total[OW-1:0];
`else
  assign result  = OW'(partial + ACCW'(bias_q));
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    yvalid_d  = yvalid_q;
    ydata_d   = ydata_q;
    x_ready_o = 1'b0;
`ifdef LRM_SAT_EN
    ysat_d    = ysat_q;
`endif
    case (state_q)
      IDLE: begin
        x_ready_o = 1'b1;
        if (x_valid_i) begin
          acc_d   = partial;
          idx_d   = AW'(1);
          state_d = ACC;
        end
      end
      ACC: begin
        x_ready_o = 1'b1;
        if (x_valid_i) begin
          if (idx_q == AW'(N_FEAT - 1)) begin
            ydata_d  = result;
            yvalid_d = 1'b1;
            idx_d    = '0;
            state_d  = OUT;
`ifdef LRM_SAT_EN
            ysat_d   = sat_hit;
`endif
          end else begin
            acc_d = partial;
            idx_d = idx_q + AW'(1);
          end
        end
      end
      OUT: begin
        if (y_ready_i) begin
          yvalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      idx_q    <= '0;
      yvalid_q <= 1'b0;
      ydata_q  <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      yvalid_q <= yvalid_d;
      ydata_q  <= ydata_d;
    end
  end

`ifdef LRM_SAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ysat_q <= 1'b0;
    else     ysat_q <= ysat_d;
  end
  assign y_sat_o = ysat_q;
`else
  assign y_sat_o = 1'b0;
`endif

  // Config is only safe to change while no inference is in flight
  assign cfg_hit  = cfg_we_i && (state_q == IDLE) && (cfg_addr_i <= AW'(N_FEAT));
  assign cfg_drop = cfg_we_i && !cfg_hit;

  always_comb begin
    cfg_err_d = cfg_err_q;
    if (cfg_drop)           cfg_err_d = 1'b1;
    else if (cfg_err_clr_i) cfg_err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_FEAT; i++) w_q[i] <= '0;
      bias_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_err_d;
      if (cfg_hit) begin
        if (cfg_addr_i == AW'(N_FEAT)) bias_q <= cfg_wdata_i;
        for (int i = 0; i < N_FEAT; i++) begin
          if (cfg_addr_i == AW'(i)) w_q[i] <= cfg_wdata_i;
        end
      end
    end
  end

  assign cfg_err_o = cfg_err_q;
  assign y_valid_o = yvalid_q;
  assign y_data_o  = ydata_q;
  assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_lr_infer_ctrl.sv
// Bench for lr_infer_ctrl: a per-inference arithmetic model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_lr_infer_ctrl;
  localparam int N_FEAT = 4;
  localparam int DW     = 4;
  localparam int OW     = 8;
  localparam int AW     = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [DW-1:0] cfg_wdata = '0;
  logic          cfg_err;
  logic          cfg_err_clr = 1'b0;
  logic          x_valid = 1'b0;
  logic          x_ready;
  logic [DW-1:0] x_data = '0;
  logic          y_valid;
  logic          y_ready = 1'b1;
  logic [OW-1:0] y_data;
  logic          y_sat;
  logic          busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  lr_infer_ctrl #(.N_FEAT(N_FEAT), .DW(DW), .OW(OW)) dut (
    .clk(clk), .rst(rst),
    .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr), .cfg_wdata_i(cfg_wdata),
    .cfg_err_o(cfg_err), .cfg_err_clr_i(cfg_err_clr),
    .x_valid_i(x_valid), .x_ready_o(x_ready), .x_data_i(x_data),
    .y_valid_o(y_valid), .y_ready_i(y_ready), .y_data_o(y_data),
    .y_sat_o(y_sat), .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  // Model: weights, bias, features accepted so far and the pending result
  int mW[N_FEAT] = '{default: 0};
  int mB = 0;
  int mCnt = 0;
  int mSum = 0;
  bit mErr = 0;
  bit mOut = 0;
  int mY = 0;
  bit mSat = 0;

  always @(posedge clk or posedge rst) begin
    bit idleNow;
    bit drop;
    int s;
    if (rst) begin
      for (int i = 0; i < N_FEAT; i++) mW[i] = 0;
      mB = 0; mCnt = 0; mSum = 0; mErr = 0; mOut = 0; mY = 0; mSat = 0;
    end else begin
      idleNow = !mOut && (mCnt == 0);
      if (mOut) begin
        if (y_ready) mOut = 0;
      end else if (x_valid) begin
        mSum = mSum + mW[mCnt] * int'(x_data);
        mCnt++;
        if (mCnt == N_FEAT) begin
          s = mSum + mB;
`ifdef LRM_SAT_EN
          mSat = (s > 255);
          mY = mSat ? 255 : s;
`else
          mSat = 0;
          mY = s % 256;
`endif
          mOut = 1; mCnt = 0; mSum = 0;
        end
      end
      drop = cfg_we && !(idleNow && int'(cfg_addr) <= N_FEAT);
      if (cfg_we && !drop) begin
        if (int'(cfg_addr) == N_FEAT) mB = int'(cfg_wdata);
        else mW[cfg_addr] = int'(cfg_wdata);
      end
      if (drop) mErr = 1;
      else if (cfg_err_clr) mErr = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("y_valid", 32'(y_valid), 32'(mOut));
      if (mOut) begin
        checkOutput("y_data", 32'(y_data), 32'(mY));
        checkOutput("y_sat", 32'(y_sat), 32'(mSat));
      end
      checkOutput("x_ready", 32'(x_ready), 32'(!mOut));
      checkOutput("busy", 32'(busy), 32'(mOut || mCnt > 0));
      checkOutput("cfg_err", 32'(cfg_err), 32'(mErr));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfgWrite(input int a, input int d);
    cfg_we = 1'b1; cfg_addr = AW'(a); cfg_wdata = DW'(d);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic sendX(input int v);
    bit took = 0;
    x_valid = 1'b1; x_data = DW'(v);
    for (int t = 0; t < 20 && !took; t++) begin
      @(negedge clk);
      took = x_ready;
      step();
    end
    x_valid = 1'b0;
    if (!took) checkOutput("x_accept_timeout", 0, 1);
  endtask

  task automatic loadBasic();
    for (int i = 0; i < N_FEAT; i++) cfgWrite(i, i + 1);
    cfgWrite(N_FEAT, 5);
  endtask

  task automatic clearErr();
    cfg_err_clr = 1'b1;
    step();
    cfg_err_clr = 1'b0;
  endtask

  task automatic applyStimulus();
    int t1, t2;
    step(); step();
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_y_valid", 32'(y_valid), 0);
    checkOutput("rst_y_data", 32'(y_data), 0);
    checkOutput("rst_cfg_err", 32'(cfg_err), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    step();

    // Basic: w={1,2,3,4}, b=5, x all 1 -> 15, visible right after last handshake
    loadBasic();
    for (int i = 0; i < N_FEAT; i++) sendX(1);
    @(negedge clk);
    checkOutput("basic_latency", 32'(y_valid), 1);
    checkOutput("basic_y", 32'(y_data), 15);
    checkOutput("basic_busy", 32'(busy), 1);
    step();
    @(negedge clk);
    checkOutput("basic_idle", 32'(busy), 0);
    step();

    // Overflow: 4*15*15 + 15 = 915
    for (int i = 0; i <= N_FEAT; i++) cfgWrite(i, 15);
    for (int i = 0; i < N_FEAT; i++) sendX(15);
    @(negedge clk);
`ifdef LRM_SAT_EN
    checkOutput("ovf_y", 32'(y_data), 255);
    checkOutput("ovf_sat", 32'(y_sat), 1);
`else
    checkOutput("ovf_y", 32'(y_data), 147);
    checkOutput("ovf_sat", 32'(y_sat), 0);
`endif
    step();

    // Gaps and backpressure: x={2,0,1,3} -> 2+0+3+12+5 = 22
    loadBasic();
    y_ready = 1'b0;
    sendX(2); step(); sendX(0); step(); sendX(1); step(); sendX(3);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("bp_y_hold", 32'(y_data), 22);
      checkOutput("bp_x_ready", 32'(x_ready), 0);
    end
    y_ready = 1'b1;
    step();
    @(negedge clk);
    checkOutput("bp_released", 32'(y_valid), 0);
    step();

    // Config protection
    sendX(1);
    cfgWrite(2, 9);
    @(negedge clk);
    checkOutput("cfg_acc_drop", 32'(cfg_err), 1);
    step();
    clearErr();
    @(negedge clk);
    checkOutput("cfg_clr", 32'(cfg_err), 0);
    step();
    for (int i = 1; i < N_FEAT; i++) sendX(1);
    @(negedge clk);
    checkOutput("cfg_w_kept", 32'(y_data), 15);
    step();
    cfgWrite(7, 3);
    @(negedge clk);
    checkOutput("cfg_bad_addr", 32'(cfg_err), 1);
    step();
    clearErr();
    cfg_we = 1'b1; cfg_addr = AW'(6); cfg_wdata = DW'(1); cfg_err_clr = 1'b1;
    step();
    cfg_we = 1'b0; cfg_err_clr = 1'b0;
    @(negedge clk);
    checkOutput("cfg_set_wins", 32'(cfg_err), 1);
    step();
    clearErr();

    // Reset mid-inference, then weights are all zero
    sendX(5); sendX(6);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_y_valid", 32'(y_valid), 0);
    checkOutput("midrst_busy", 32'(busy), 0);
    step();
    rst = 1'b0;
    step();
    for (int i = 0; i < N_FEAT; i++) sendX(9);
    @(negedge clk);
    checkOutput("midrst_valid", 32'(y_valid), 1);
    checkOutput("midrst_y", 32'(y_data), 0);
    step();

    // Back-to-back: 1+4+9+16+5 = 35, then 4+6+6+4+5 = 25
    loadBasic();
    for (int i = 1; i <= N_FEAT; i++) sendX(i);
    @(negedge clk);
    t1 = cyc;
    checkOutput("b2b_first", 32'(y_data), 35);
    step();
    for (int i = N_FEAT; i >= 1; i--) sendX(i);
    @(negedge clk);
    t2 = cyc;
    checkOutput("b2b_second", 32'(y_data), 25);
    checkOutput("b2b_gap", 32'(t2 - t1), 5);
    step();
  endtask

  initial begin
    applyStimulus();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
